// File: rtl/ahb_mem_ws.sv
// AHB-Lite memory slave with programmable wait states, optional ROM mode, byte-lane
// writes with read-after-write forwarding, and a two-cycle ERROR response for illegal accesses.
module ahb_mem_ws #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 0,
  parameter int READ_ONLY   = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP
);
  localparam int         IW      = ADDR_WIDTH - 2;
  localparam int         DEPTH   = 1 << IW;
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_cnt;
  logic [2:0]      w_cnt_nxt;
  logic            r_dp_vld;
  logic            r_write;
  logic [IW-1:0]   r_idx;
  logic [3:0]      r_strb;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH];

  logic            w_acc;
  logic            w_illegal;
  logic            w_acc_ok;
  logic            w_acc_err;
  logic            w_done;
  logic            w_commit;
  logic            w_fwd;
  logic [3:0]      w_strb;
  logic [31:0]     w_mask;
  logic [31:0]     w_rd_word;
  logic [IW-1:0]   w_rd_idx;
  logic            w_unused;

  // SEQ and NONSEQ behave identically, so only HTRANS[1] matters.
  assign w_unused = HTRANS[0];

  assign w_acc     = HSEL & HREADY & HTRANS[1];
  assign w_acc_ok  = w_acc & ~w_illegal;
  assign w_acc_err = w_acc & w_illegal;

  always_comb begin
    w_illegal = 1'b0;
    if (HSIZE > 3'd2)
      w_illegal = 1'b1;
    else if ((HSIZE == 3'd1) && HADDR[0])
      w_illegal = 1'b1;
    else if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
      w_illegal = 1'b1;
    if ((READ_ONLY != 0) && HWRITE)
      w_illegal = 1'b1;
  end

  always_comb begin
    w_strb = 4'b1111;
    case (HSIZE)
      3'd0:    w_strb = 4'b0001 << HADDR[1:0];
      3'd1:    w_strb = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

  always_comb begin
    w_mask = 32'd0;
    for (int i = 0; i < 4; i++)
      w_mask[8*i +: 8] = {8{r_strb[i]}};
  end

  // The final cycle of a legal data phase is the one spent back in S_IDLE.
  assign w_done   = r_dp_vld & (r_state == S_IDLE);
  assign w_commit = w_done & r_write;
  assign w_rd_idx = HADDR[ADDR_WIDTH-1:2];
  assign w_fwd    = w_commit & (r_idx == w_rd_idx);

  // A read landing on the word being committed this edge merges in the live write lanes.
  assign w_rd_word = w_fwd ? ((HWDATA & w_mask) | (r_mem[w_rd_idx] & ~w_mask))
                           : r_mem[w_rd_idx];

  assign HRDATA = (w_done & ~r_write) ? r_rdata : 32'd0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    case (r_state)
      S_IDLE, S_ERR2: begin
        HRESP       = (r_state == S_ERR2);
        w_state_nxt = S_IDLE;
        if (w_acc_err) begin
          w_state_nxt = S_ERR1;
        end else if (w_acc_ok && (WAIT_STATES > 0)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = WS_LOAD;
        end
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (r_cnt == 3'd0)
          w_state_nxt = S_IDLE;
        else
          w_cnt_nxt = r_cnt - 3'd1;
      end
      S_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        w_state_nxt = S_ERR2;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_dp_vld <= 1'b0;
      r_write  <= 1'b0;
      r_idx    <= '0;
      r_strb   <= 4'd0;
      r_rdata  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (HREADYOUT) begin
        r_dp_vld <= w_acc_ok;
        if (w_acc_ok) begin
          r_idx   <= w_rd_idx;
          r_write <= HWRITE;
          r_strb  <= w_strb;
          if (!HWRITE)
            r_rdata <= w_rd_word;
        end
      end
    end
  end

  // Array is deliberately not reset; a reset drops r_dp_vld and so discards a pending write.
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++)
        if (r_strb[i])
          r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_mem_ws.sv
// Scoreboard bench for ahb_mem_ws: three instances (zero-wait RAM, 3-wait RAM, zero-wait ROM)
// share one AHB bus; a per-instance array model supplies expected responses.
module tb_ahb_mem_ws;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic [7:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  wire  [2:0]  rdy;
  wire  [2:0]  resp;
  wire  [31:0] rd0, rd1, rd2;

  always #5 clk = ~clk;

  ahb_mem_ws #(.ADDR_WIDTH(8), .WAIT_STATES(0), .READ_ONLY(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[0]), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy[0]), .HREADYOUT(rdy[0]), .HRDATA(rd0), .HRESP(resp[0]));
  ahb_mem_ws #(.ADDR_WIDTH(8), .WAIT_STATES(3), .READ_ONLY(0)) dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[1]), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy[1]), .HREADYOUT(rdy[1]), .HRDATA(rd1), .HRESP(resp[1]));
  ahb_mem_ws #(.ADDR_WIDTH(6), .WAIT_STATES(0), .READ_ONLY(1)) dut2 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[2]), .HADDR(haddr[5:0]), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy[2]), .HREADYOUT(rdy[2]), .HRDATA(rd2), .HRESP(resp[2]));

  typedef struct {
    bit          err;
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m [3][64];
  int          cur = 0;
  int          tests = 0;
  int          fails = 0;
  bit          mon_act = 1'b0;
  int          mon_i = 0;
  exp_t        mon_e;

  wire [31:0] rd_cur = (cur == 0) ? rd0 : (cur == 1) ? rd1 : rd2;

  function automatic int nws(int k);
    return (k == 1) ? 3 : 0;
  endfunction
  function automatic int aw(int k);
    return (k == 2) ? 6 : 8;
  endfunction
  function automatic bit ro(int k);
    return (k == 2);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (inst %0d, t=%0t): got %h, want %h", name, cur, $time, act, exp);
    end
  endtask

  // Monitor: checks every cycle of the active instance against the popped expectation.
  always @(negedge clk) begin
    bit          er, ep;
    logic [31:0] ed;
    if (rst) begin
      mon_act = 1'b0;
      chk("reset_ready", 32'(rdy[cur]), 32'd1);
      chk("reset_resp",  32'(resp[cur]), 32'd0);
      chk("reset_rdata", rd_cur, 32'd0);
    end else begin
      if (mon_act) begin
        if (mon_e.err) begin
          er = (mon_i == 1); ep = 1'b1; ed = 32'd0;
        end else begin
          er = (mon_i == nws(cur)); ep = 1'b0;
          ed = (er && !mon_e.wr) ? mon_e.data : 32'd0;
        end
        chk("dp_ready", 32'(rdy[cur]), 32'(er));
        chk("dp_resp",  32'(resp[cur]), 32'(ep));
        chk("dp_rdata", rd_cur, ed);
        if (rdy[cur]) begin
          mon_act = 1'b0;
        end else begin
          mon_i++;
          if (mon_i > 20) begin
            chk("dp_stuck_low", 32'd0, 32'd1);
            mon_act = 1'b0;
          end
        end
      end else begin
        chk("idle_ready", 32'(rdy[cur]), 32'd1);
        chk("idle_resp",  32'(resp[cur]), 32'd0);
        chk("idle_rdata", rd_cur, 32'd0);
      end
      if (sel[cur] && htrans[1] && rdy[cur]) begin
        if (q.size() == 0) begin
          chk("accept_without_expectation", 32'd1, 32'd0);
        end else begin
          mon_e   = q.pop_front();
          mon_act = 1'b1;
          mon_i   = 0;
        end
      end
    end
  end

  // Drive one address phase; the model is updated in bus order (apply=0 models a discarded write).
  task automatic issue(int k, bit wr, bit [2:0] sz, bit [7:0] a, bit [31:0] wd, bit [1:0] tr, bit apply);
    exp_t e;
    int   w;
    bit   ok;
    cur    = k;
    sel    = 3'(1 << k);
    haddr  = a;
    htrans = tr;
    hsize  = sz;
    hwrite = wr;
    if (tr[1]) begin
      w = int'(a >> 2) & ((1 << (aw(k) - 2)) - 1);
      e.err  = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) || (wr && ro(k));
      e.wr   = wr;
      e.data = m[k][w];
      if (!e.err && wr && apply)
        for (int b = 0; b < (1 << sz); b++)
          m[k][w][8*(int'(a[1:0]) + b) +: 8] = wd[8*(int'(a[1:0]) + b) +: 8];
      q.push_back(e);
    end
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rdy[k]) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    hwdata = (tr[1] && wr) ? wd : $urandom;
  endtask

  task automatic bus_idle();
    sel    = 3'd0;
    htrans = 2'b00;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    bus_idle();
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !mon_act) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rand_run(int k, int n);
    bit       wr;
    bit [2:0] sz;
    bit [7:0] a;
    bit [1:0] tr;
    for (int i = 0; i < n; i++) begin
      wr = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      if (sz <= 3'd2 && $urandom_range(0, 3) != 0)
        a = a & ~8'((1 << sz) - 1);
      tr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      issue(k, wr, sz, a, $urandom, tr, 1'b1);
      if ($urandom_range(0, 9) == 0) begin
        bus_idle();
        @(posedge clk); #1;
      end
    end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 3'd0; haddr = 8'd0; htrans = 2'b00; hsize = 3'd0; hwrite = 1'b0; hwdata = 32'd0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m[2][i] = $urandom;
      dut2.r_mem[i] = m[2][i];
    end
    m[2][0] = 32'h0BAD_C0DE;
    dut2.r_mem[0] = 32'h0BAD_C0DE;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 64; w++)
        issue(k, 1'b1, 3'd2, 8'(w * 4), $urandom, 2'b10, 1'b1);
      drain();
    end

    // Forwarding: write then back-to-back read of the same word
    issue(0, 1'b1, 3'd2, 8'h10, 32'h1234_5678, 2'b10, 1'b1);
    issue(0, 1'b0, 3'd2, 8'h10, 32'h0, 2'b10, 1'b1);
    // Byte lanes
    issue(0, 1'b1, 3'd2, 8'h40, 32'hFFFF_FFFF, 2'b10, 1'b1);
    issue(0, 1'b1, 3'd0, 8'h42, 32'h00A5_0000, 2'b10, 1'b1);
    issue(0, 1'b1, 3'd1, 8'h40, 32'h0000_1234, 2'b10, 1'b1);
    issue(0, 1'b0, 3'd2, 8'h40, 32'h0, 2'b10, 1'b1);
    // Errors, then confirm the array is untouched
    issue(0, 1'b0, 3'd2, 8'h41, 32'h0, 2'b10, 1'b1);
    issue(0, 1'b1, 3'd1, 8'h41, 32'hDEAD_BEEF, 2'b10, 1'b1);
    issue(0, 1'b1, 3'd3, 8'h40, 32'hDEAD_BEEF, 2'b10, 1'b1);
    issue(0, 1'b0, 3'd2, 8'h40, 32'h0, 2'b10, 1'b1);
    // Address wrap past the top word
    issue(0, 1'b1, 3'd0, 8'hFF, 32'h1100_0000, 2'b10, 1'b1);
    issue(0, 1'b0, 3'd2, 8'hFC, 32'h0, 2'b10, 1'b1);
    issue(0, 1'b0, 3'd2, 8'h00, 32'h0, 2'b11, 1'b1);
    issue(0, 1'b1, 3'd2, 8'hFC, 32'hA1B2_C3D4, 2'b10, 1'b1);
    issue(0, 1'b1, 3'd2, 8'h00, 32'h5566_7788, 2'b11, 1'b1);
    issue(0, 1'b0, 3'd2, 8'h00, 32'h0, 2'b10, 1'b1);
    drain();

    // Wait states
    issue(1, 1'b1, 3'd2, 8'h20, 32'hCAFE_F00D, 2'b10, 1'b1);
    issue(1, 1'b0, 3'd2, 8'h20, 32'h0, 2'b10, 1'b1);
    issue(1, 1'b0, 3'd2, 8'h23, 32'h0, 2'b10, 1'b1);
    issue(1, 1'b0, 3'd2, 8'h20, 32'h0, 2'b10, 1'b1);
    drain();

    // Reset on the 2nd wait cycle of a write: outputs recover at once, write is dropped
    issue(1, 1'b1, 3'd2, 8'h80, 32'h5A5A_0F0F, 2'b10, 1'b0);
    bus_idle();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_reset_ready", 32'(rdy[1]), 32'd1);
    chk("async_reset_resp",  32'(resp[1]), 32'd0);
    chk("async_reset_rdata", rd1, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    issue(1, 1'b0, 3'd2, 8'h80, 32'h0, 2'b10, 1'b1);
    drain();

    // ROM: write errors, old data survives
    issue(2, 1'b0, 3'd2, 8'h00, 32'h0, 2'b10, 1'b1);
    issue(2, 1'b1, 3'd2, 8'h00, 32'hDEAD_BEEF, 2'b10, 1'b1);
    issue(2, 1'b0, 3'd2, 8'h00, 32'h0, 2'b10, 1'b1);
    drain();

    rand_run(0, 200);
    rand_run(1, 120);
    rand_run(2, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
